// File: rtl/add3_pkg.sv
// Shared types for the 3-bit adder result capture path.
package add3_pkg;

  localparam int unsigned SUM_W = 3;

  // One captured adder result: carry-out above the 3-bit sum.
  typedef struct packed {
    logic             cout;
    logic [SUM_W-1:0] sum;
  } add3_result_t;

endpackage : add3_pkg

// File: rtl/add3_fifo_core.sv
// Storage, pointers and occupancy for the result FIFO; no handshake logic here.
module add3_fifo_core
  import add3_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  add3_result_t       wdata_i,
  input  logic               pop_i,
  output add3_result_t       rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LVL_W-1:0]   level_o
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  add3_result_t           mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;

  // Next pointer and occupancy values from the push/pop strobes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_i && !pop_i)      level_d = level_q + LVL_W'(1);
    else if (pop_i && !push_i) level_d = level_q - LVL_W'(1);
  end

  // Pointer/level registers and storage; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule : add3_fifo_core

// File: rtl/add3_result_fifo.sv
// Capture stage for adder results: FIFO handshake plus running total and sticky carry.
module add3_result_fifo
  import add3_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ACC_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [SUM_W-1:0]           in_sum,
  input  logic                       in_cout,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output add3_result_t               out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [ACC_W-1:0]           acc_total,
  output logic                       carry_seen,
  input  logic                       clr_stats
);

  add3_result_t     push_data;
  logic             push, pop;
  logic             full, empty;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;

  assign push_data = '{cout: in_cout, sum: in_sum};
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  add3_fifo_core #(
    .DEPTH(DEPTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (out_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Statistics next state: a clear zeroes first, then the same-cycle push folds in.
  always_comb begin
    acc_d   = clr_stats ? '0 : acc_q;
    carry_d = clr_stats ? 1'b0 : carry_q;
    if (push) begin
      acc_d   = acc_d + ACC_W'(push_data);
      carry_d = carry_d | in_cout;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign acc_total  = acc_q;
  assign carry_seen = carry_q;

endmodule : add3_result_fifo

// File: tb/tb_add3_result_fifo.sv
// Directed bench for add3_result_fifo with hand-computed expectations.
module tb_add3_result_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_sum;
  logic       in_cout;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] level;
  logic [5:0] acc_total;
  logic       carry_seen;
  logic       clr_stats;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [3:0]  q[$];
  logic [3:0]  v;

  add3_result_fifo #(.DEPTH(4), .ACC_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sum     (in_sum),
    .in_cout    (in_cout),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .acc_total  (acc_total),
    .carry_seen (carry_seen),
    .clr_stats  (clr_stats)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold inputs for one clock edge, then return them to idle 1ns after it.
  task automatic cyc(input logic iv, input logic [3:0] d, input logic ordy, input logic clr);
    in_valid  = iv;
    {in_cout, in_sum} = d;
    out_ready = ordy;
    clr_stats = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0;
    out_ready = 1'b0; clr_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_acc", 32'(acc_total), 0);
    check("rst_carry", 32'(carry_seen), 0);
    check("rst_out_data", 32'(out_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic captures: 6+1 -> {0,7}, then 5+4 -> {1,1}.
    cyc(1, 4'h7, 0, 0);
    check("b1_valid", 32'(out_valid), 1);
    check("b1_data", 32'(out_data), 32'h7);
    check("b1_acc", 32'(acc_total), 7);
    check("b1_carry", 32'(carry_seen), 0);
    cyc(0, 4'h0, 1, 0);
    check("b1_pop_empty", 32'(out_valid), 0);
    cyc(1, 4'h9, 0, 0);
    check("b2_data", 32'(out_data), 32'h9);
    check("b2_acc", 32'(acc_total), 16);
    check("b2_carry", 32'(carry_seen), 1);
    cyc(0, 4'h0, 1, 0);
    check("b2_level", 32'(level), 0);

    // Fill and stall; a 5th push is refused and does not touch the total.
    cyc(1, 4'h5, 0, 0);
    cyc(1, 4'h7, 0, 0);
    cyc(1, 4'h9, 0, 0);
    cyc(1, 4'h0, 0, 0);
    check("fill_level", 32'(level), 4);
    check("fill_in_ready", 32'(in_ready), 0);
    check("fill_acc", 32'(acc_total), 37);
    cyc(1, 4'h3, 0, 0);
    check("refuse_level", 32'(level), 4);
    check("refuse_acc", 32'(acc_total), 37);
    q = '{4'h5, 4'h7, 4'h9, 4'h0};
    foreach (q[i]) begin
      check("drain_valid", 32'(out_valid), 1);
      check("drain_data", 32'(out_data), 32'(q[i]));
      cyc(0, 4'h0, 1, 0);
    end
    check("drain_empty", 32'(out_valid), 0);

    // Simultaneous push/pop at level 2 across pointer wrap.
    q.delete();
    cyc(1, 4'h1, 0, 0); q.push_back(4'h1);
    cyc(1, 4'h2, 0, 0); q.push_back(4'h2);
    for (int i = 0; i < 10; i++) begin
      v = 4'(4'h3 + 4'(i));
      check("pp_data", 32'(out_data), 32'(q[0]));
      cyc(1, v, 1, 0);
      void'(q.pop_front());
      q.push_back(v);
      check("pp_level", 32'(level), 2);
    end
    while (q.size() > 0) begin
      check("pp_tail", 32'(out_data), 32'(q.pop_front()));
      cyc(0, 4'h0, 1, 0);
    end
    check("pp_empty", 32'(level), 0);

    // Full with pop: push refused, level drops to 3.
    cyc(1, 4'h1, 0, 0);
    cyc(1, 4'h2, 0, 0);
    cyc(1, 4'h3, 0, 0);
    cyc(1, 4'h4, 0, 0);
    cyc(1, 4'h5, 1, 0);
    check("fp_level", 32'(level), 3);
    check("fp_in_ready", 32'(in_ready), 1);
    q = '{4'h2, 4'h3, 4'h4};
    foreach (q[i]) begin
      check("fp_order", 32'(out_data), 32'(q[i]));
      cyc(0, 4'h0, 1, 0);
    end
    check("fp_empty", 32'(out_valid), 0);

    // Accumulator wrap: 8 x 15 = 120 -> 56 mod 64; then clear with a push of 3.
    cyc(0, 4'h0, 0, 1);
    check("clr_acc", 32'(acc_total), 0);
    check("clr_carry", 32'(carry_seen), 0);
    for (int i = 0; i < 8; i++) cyc(1, 4'hF, 1, 0);
    check("wrap_acc", 32'(acc_total), 56);
    check("wrap_carry", 32'(carry_seen), 1);
    check("wrap_level", 32'(level), 1);
    cyc(1, 4'h3, 1, 1);
    check("clrpush_acc", 32'(acc_total), 3);
    check("clrpush_carry", 32'(carry_seen), 0);
    check("clrpush_data", 32'(out_data), 32'h3);
    cyc(0, 4'h0, 1, 0);

    // Reset mid-operation at level 3.
    cyc(1, 4'hA, 0, 0);
    cyc(1, 4'hB, 0, 0);
    cyc(1, 4'hC, 0, 0);
    check("pre_rst_level", 32'(level), 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_acc", 32'(acc_total), 0);
    check("mid_rst_carry", 32'(carry_seen), 0);
    check("mid_rst_data", 32'(out_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, 4'h6, 0, 0);
    check("post_rst_data", 32'(out_data), 32'h6);
    check("post_rst_level", 32'(level), 1);
    check("post_rst_acc", 32'(acc_total), 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_add3_result_fifo
